// File: rtl/tlb_asid_sp.sv
// rtl/tlb_asid_sp.sv - fully-associative L1 TLB with ASID tags, global pages, Sv39 superpages and selective invalidation
// Lookup is registered (one-cycle latency); refills come from the page-table walker.
module tlb_asid_sp #(
    parameter int LG_N   = 3,
    parameter int ASID_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              active,
    input  logic              req,
    input  logic [63:0]       va,
    input  logic [ASID_W-1:0] asid,
    output logic [63:0]       pa,
    output logic              hit,
    output logic              dirty,
    output logic              readable,
    output logic              writable,
    output logic              executable,
    output logic              user,
    input  logic              replace,
    input  logic [63:0]       replace_va,
    input  logic [63:0]       replace_pa,
    input  logic [ASID_W-1:0] replace_asid,
    input  logic              replace_global,
    input  logic [1:0]        replace_size,
    input  logic              replace_dirty,
    input  logic              replace_readable,
    input  logic              replace_writable,
    input  logic              replace_executable,
    input  logic              replace_user,
    input  logic              inv,
    input  logic              inv_use_va,
    input  logic              inv_use_asid,
    input  logic [63:0]       inv_va,
    input  logic [ASID_W-1:0] inv_asid
);
    localparam int N = 1 << LG_N;

    logic [N-1:0]      valid_q, valid_d;
    logic [26:0]       vpn_q  [N];
    logic [26:0]       vpn_d  [N];
    logic [43:0]       ppn_q  [N];
    logic [43:0]       ppn_d  [N];
    logic [ASID_W-1:0] asid_q [N];
    logic [ASID_W-1:0] asid_d [N];
    logic [N-1:0]      glob_q, glob_d;
    logic [1:0]        size_q [N];
    logic [1:0]        size_d [N];
    // Permission order: {dirty, readable, writable, executable, user}
    logic [4:0]        perm_q [N];
    logic [4:0]        perm_d [N];
    logic [LG_N-1:0]   r_cnt_q, r_cnt_d;

    logic              hit_q, hit_d;
    logic [63:0]       pa_q, pa_d;
    logic [4:0]        out_perm_q, out_perm_d;

    logic              any_hit;
    logic [LG_N-1:0]   sel;
    logic [1:0]        rep_size;
    logic              dup, free, use_rr;
    logic [LG_N-1:0]   dup_idx, free_idx, tgt;
    logic [N-1:0]      kill;

    logic unused_bits;
    assign unused_bits = ^{replace_va[63:39], replace_va[11:0], replace_pa[63:56],
                           replace_pa[11:0], inv_va[63:39], inv_va[11:0]};

    function automatic logic vpn_match(input logic [26:0] e, input logic [1:0] sz,
                                       input logic [26:0] v);
        case (sz)
            2'd1:    return e[26:9] == v[26:9];
            2'd2:    return e[26:18] == v[26:18];
            default: return e == v;
        endcase
    endfunction

    // Descending scan so the lowest matching index wins.
    always_comb begin
        any_hit = 1'b0;
        sel     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_q[i] && vpn_match(vpn_q[i], size_q[i], va[38:12]) &&
                (glob_q[i] || asid_q[i] == asid)) begin
                any_hit = 1'b1;
                sel     = LG_N'(i);
            end
        end
    end

    always_comb begin
        hit_d      = 1'b0;
        pa_d       = 64'd0;
        out_perm_d = 5'd0;
        if (!active) begin
            hit_d      = 1'b1;
            pa_d       = va;
            out_perm_d = 5'b11111;
        end else if (req && any_hit) begin
            hit_d      = 1'b1;
            out_perm_d = perm_q[sel];
            case (size_q[sel])
                2'd1:    pa_d = {8'd0, ppn_q[sel][43:9], va[20:0]};
                2'd2:    pa_d = {8'd0, ppn_q[sel][43:18], va[29:0]};
                default: pa_d = {8'd0, ppn_q[sel], va[11:0]};
            endcase
        end
    end

    // Target choice looks at pre-invalidate valid bits.
    always_comb begin
        rep_size = (replace_size == 2'd3) ? 2'd0 : replace_size;
        dup      = 1'b0;
        dup_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_q[i] && size_q[i] == rep_size &&
                vpn_match(vpn_q[i], rep_size, replace_va[38:12]) &&
                (glob_q[i] || asid_q[i] == replace_asid)) begin
                dup     = 1'b1;
                dup_idx = LG_N'(i);
            end
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = LG_N'(i);
            end
        end
        use_rr = !dup && !free;
        tgt    = dup ? dup_idx : (free ? free_idx : r_cnt_q);
    end

    always_comb begin
        kill = '0;
        for (int i = 0; i < N; i++) begin
            kill[i] = (!inv_use_va || vpn_match(vpn_q[i], size_q[i], inv_va[38:12])) &&
                      (!inv_use_asid || (!glob_q[i] && asid_q[i] == inv_asid));
        end
    end

    always_comb begin
        valid_d = valid_q;
        vpn_d   = vpn_q;
        ppn_d   = ppn_q;
        asid_d  = asid_q;
        glob_d  = glob_q;
        size_d  = size_q;
        perm_d  = perm_q;
        r_cnt_d = r_cnt_q;
        if (clear) begin
            valid_d = '0;
        end else begin
            if (inv) begin
                valid_d = valid_d & ~kill;
            end
            if (replace) begin
                valid_d[tgt] = 1'b1;
                vpn_d[tgt]   = replace_va[38:12];
                ppn_d[tgt]   = replace_pa[55:12];
                asid_d[tgt]  = replace_asid;
                glob_d[tgt]  = replace_global;
                size_d[tgt]  = rep_size;
                perm_d[tgt]  = {replace_dirty, replace_readable, replace_writable,
                                replace_executable, replace_user};
                if (use_rr) begin
                    r_cnt_d = r_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            r_cnt_q    <= '0;
            hit_q      <= 1'b0;
            pa_q       <= 64'd0;
            out_perm_q <= 5'd0;
        end else begin
            valid_q    <= valid_d;
            r_cnt_q    <= r_cnt_d;
            hit_q      <= hit_d;
            pa_q       <= pa_d;
            out_perm_q <= out_perm_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        vpn_q  <= vpn_d;
        ppn_q  <= ppn_d;
        asid_q <= asid_d;
        glob_q <= glob_d;
        size_q <= size_d;
        perm_q <= perm_d;
    end

    assign hit        = hit_q;
    assign pa         = pa_q;
    assign dirty      = out_perm_q[4];
    assign readable   = out_perm_q[3];
    assign writable   = out_perm_q[2];
    assign executable = out_perm_q[1];
    assign user       = out_perm_q[0];
endmodule

// File: tb/tb_tlb_asid_sp.sv
// tb/tb_tlb_asid_sp.sv - directed self-checking bench for tlb_asid_sp
module tb_tlb_asid_sp;
    logic        clk = 1'b0;
    logic        reset, clear, active, req;
    logic [63:0] va;
    logic [15:0] asid;
    logic [63:0] pa;
    logic        hit, dirty, readable, writable, executable, user;
    logic        replace;
    logic [63:0] replace_va, replace_pa;
    logic [15:0] replace_asid;
    logic        replace_global;
    logic [1:0]  replace_size;
    logic        replace_dirty, replace_readable, replace_writable, replace_executable, replace_user;
    logic        inv, inv_use_va, inv_use_asid;
    logic [63:0] inv_va;
    logic [15:0] inv_asid;
    logic [4:0]  perm;
    int          checks = 0;
    int          errors = 0;

    assign perm = {dirty, readable, writable, executable, user};

    always #5 clk = ~clk;

    tlb_asid_sp #(.LG_N(3), .ASID_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .active(active), .req(req), .va(va),
        .asid(asid), .pa(pa), .hit(hit), .dirty(dirty), .readable(readable),
        .writable(writable), .executable(executable), .user(user), .replace(replace),
        .replace_va(replace_va), .replace_pa(replace_pa), .replace_asid(replace_asid),
        .replace_global(replace_global), .replace_size(replace_size),
        .replace_dirty(replace_dirty), .replace_readable(replace_readable),
        .replace_writable(replace_writable), .replace_executable(replace_executable),
        .replace_user(replace_user), .inv(inv), .inv_use_va(inv_use_va),
        .inv_use_asid(inv_use_asid), .inv_va(inv_va), .inv_asid(inv_asid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_refill(input logic [63:0] v, input logic [63:0] p, input logic [15:0] a,
                              input logic g, input logic [1:0] sz, input logic [4:0] pm);
        replace_va = v; replace_pa = p; replace_asid = a; replace_global = g;
        replace_size = sz;
        {replace_dirty, replace_readable, replace_writable, replace_executable, replace_user} = pm;
    endtask

    task automatic refill(input logic [63:0] v, input logic [63:0] p, input logic [15:0] a,
                          input logic g, input logic [1:0] sz, input logic [4:0] pm);
        set_refill(v, p, a, g, sz, pm);
        replace = 1'b1;
        tick();
        replace = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] v, input logic [15:0] a);
        va = v; asid = a; req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic do_inv(input logic uva, input logic uas, input logic [63:0] v, input logic [15:0] a);
        inv = 1'b1; inv_use_va = uva; inv_use_asid = uas; inv_va = v; inv_asid = a;
        tick();
        inv = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        active = 1'b1;
        lookup(64'h1234, 16'd0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
        checks++; if (pa !== 64'd0) begin errors++; $display("FAIL reset_pa: got %h want 0", pa); end
        checks++; if (perm !== 5'b00000) begin errors++; $display("FAIL reset_perm: got %b want 00000", perm); end
        active = 1'b0;
        lookup(64'hDEAD_B000, 16'd0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL bare_hit: got %b want 1", hit); end
        checks++; if (pa !== 64'hDEAD_B000) begin errors++; $display("FAIL bare_pa: got %h want deadb000", pa); end
        checks++; if (perm !== 5'b11111) begin errors++; $display("FAIL bare_perm: got %b want 11111", perm); end
        active = 1'b1;
    endtask

    task automatic test_4k();
        refill(64'h4000_5000, 64'h8_0001_2000, 16'd3, 1'b0, 2'd0, 5'b01100);
        lookup(64'h4000_5ABC, 16'd3);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL 4k_hit: got %b want 1", hit); end
        checks++; if (pa !== 64'h8_0001_2ABC) begin errors++; $display("FAIL 4k_pa: got %h want 800012abc", pa); end
        checks++; if (perm !== 5'b01100) begin errors++; $display("FAIL 4k_perm: got %b want 01100", perm); end
        lookup(64'h4000_5ABC, 16'd4);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL 4k_wrong_asid: got %b want 0", hit); end
        checks++; if (perm !== 5'b00000) begin errors++; $display("FAIL 4k_miss_perm: got %b want 00000", perm); end
        refill(64'h4000_5000, 64'h8_0001_2000, 16'd3, 1'b1, 2'd0, 5'b01100);
        lookup(64'h4000_5ABC, 16'd4);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL 4k_global: got %b want 1", hit); end
        checks++; if (pa !== 64'h8_0001_2ABC) begin errors++; $display("FAIL 4k_global_pa: got %h want 800012abc", pa); end
    endtask

    task automatic test_superpage();
        refill(64'h4020_0000, 64'h8000_0000, 16'd3, 1'b0, 2'd1, 5'b01000);
        lookup(64'h4023_4567, 16'd3);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL 2m_hit: got %b want 1", hit); end
        checks++; if (pa !== 64'h8003_4567) begin errors++; $display("FAIL 2m_pa: got %h want 80034567", pa); end
        refill(64'h8000_0000, 64'h1_0000_0000, 16'd3, 1'b0, 2'd2, 5'b00010);
        lookup(64'hBFFF_FFF0, 16'd3);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL 1g_hit: got %b want 1", hit); end
        checks++; if (pa !== 64'h1_3FFF_FFF0) begin errors++; $display("FAIL 1g_pa: got %h want 13ffffff0", pa); end
        checks++; if (perm !== 5'b00010) begin errors++; $display("FAIL 1g_perm: got %b want 00010", perm); end
        refill(64'h7000_0000, 64'h2000, 16'd3, 1'b0, 2'd3, 5'b00001);
        lookup(64'h7000_0123, 16'd3);
        checks++; if (pa !== 64'h2123 || hit !== 1'b1) begin errors++; $display("FAIL size3_pa: got hit=%b pa=%h want hit=1 pa=2123", hit, pa); end
        lookup(64'h7000_1123, 16'd3);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL size3_is_4k: got %b want 0", hit); end
    endtask

    task automatic test_fill();
        do_clear();
        for (int k = 0; k < 8; k++)
            refill(64'h10_0000 + 64'(k) * 64'h1000, 64'h20_0000 + 64'(k) * 64'h1000, 16'd5, 1'b0, 2'd0, 5'b01000);
        for (int k = 0; k < 8; k++) begin
            lookup(64'h10_0000 + 64'(k) * 64'h1000 + 64'h10, 16'd5);
            checks++; if (hit !== 1'b1 || pa !== 64'h20_0000 + 64'(k) * 64'h1000 + 64'h10) begin
                errors++; $display("FAIL fill_%0d: got hit=%b pa=%h", k, hit, pa); end
        end
        refill(64'h18_0000, 64'h28_0000, 16'd5, 1'b0, 2'd0, 5'b01000);
        lookup(64'h10_0000, 16'd5);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rr_evict0: got %b want 0", hit); end
        lookup(64'h18_0000, 16'd5);
        checks++; if (hit !== 1'b1 || pa !== 64'h28_0000) begin errors++; $display("FAIL rr_new8: got hit=%b pa=%h want 1 280000", hit, pa); end
        refill(64'h19_0000, 64'h29_0000, 16'd5, 1'b0, 2'd0, 5'b01000);
        lookup(64'h10_1000, 16'd5);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rr_evict1: got %b want 0", hit); end
        refill(64'h19_0000, 64'h90_0000, 16'd5, 1'b0, 2'd0, 5'b01000);
        lookup(64'h19_0004, 16'd5);
        checks++; if (hit !== 1'b1 || pa !== 64'h90_0004) begin errors++; $display("FAIL overwrite: got hit=%b pa=%h want 1 900004", hit, pa); end
        lookup(64'h10_2000, 16'd5);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL overwrite_no_evict: got %b want 1", hit); end
        refill(64'h1A_0000, 64'h2A_0000, 16'd5, 1'b0, 2'd0, 5'b01000);
        lookup(64'h10_2000, 16'd5);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rr_evict2: got %b want 0", hit); end
        lookup(64'h10_3000, 16'd5);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rr_keep3: got %b want 1", hit); end
    endtask

    task automatic test_inv();
        do_clear();
        refill(64'h1000, 64'hA000, 16'd1, 1'b0, 2'd0, 5'b01000);
        refill(64'h2000, 64'hB000, 16'd2, 1'b0, 2'd0, 5'b01000);
        refill(64'h3000, 64'hC000, 16'd1, 1'b1, 2'd0, 5'b01000);
        do_inv(1'b0, 1'b1, 64'h0, 16'd1);
        lookup(64'h1000, 16'd1);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_asid_A: got %b want 0", hit); end
        lookup(64'h2000, 16'd2);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL inv_asid_B: got %b want 1", hit); end
        lookup(64'h3000, 16'd1);
        checks++; if (hit !== 1'b1 || pa !== 64'hC000) begin errors++; $display("FAIL inv_asid_G: got hit=%b pa=%h want 1 c000", hit, pa); end
        do_inv(1'b1, 1'b0, 64'h3000, 16'd9);
        lookup(64'h3000, 16'd1);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_va_G: got %b want 0", hit); end
        lookup(64'h2000, 16'd2);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL inv_va_B: got %b want 1", hit); end
        do_inv(1'b0, 1'b0, 64'h0, 16'd0);
        lookup(64'h2000, 16'd2);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_all_B: got %b want 0", hit); end
    endtask

    task automatic test_same_cycle();
        do_clear();
        refill(64'h1000, 64'hA000, 16'd1, 1'b0, 2'd0, 5'b01000);
        set_refill(64'h5000, 64'hE000, 16'd1, 1'b0, 2'd0, 5'b01000);
        replace = 1'b1;
        do_inv(1'b0, 1'b0, 64'h0, 16'd0);
        replace = 1'b0;
        lookup(64'h1000, 16'd1);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL invrep_old: got %b want 0", hit); end
        lookup(64'h5000, 16'd1);
        checks++; if (hit !== 1'b1 || pa !== 64'hE000) begin errors++; $display("FAIL invrep_new: got hit=%b pa=%h want 1 e000", hit, pa); end
        set_refill(64'h6000, 64'hF000, 16'd1, 1'b0, 2'd0, 5'b01000);
        replace = 1'b1;
        do_clear();
        replace = 1'b0;
        lookup(64'h6000, 16'd1);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL clrrep_new: got %b want 0", hit); end
        lookup(64'h5000, 16'd1);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL clrrep_old: got %b want 0", hit); end
        set_refill(64'h7000, 64'hD000, 16'd1, 1'b0, 2'd0, 5'b01000);
        replace = 1'b1;
        lookup(64'h7000, 16'd1);
        replace = 1'b0;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL samecyc_lookup: got %b want 0", hit); end
        lookup(64'h7000, 16'd1);
        checks++; if (hit !== 1'b1 || pa !== 64'hD000) begin errors++; $display("FAIL nextcyc_lookup: got hit=%b pa=%h want 1 d000", hit, pa); end
        set_refill(64'h7000, 64'hD000, 16'd1, 1'b0, 2'd0, 5'b01000);
        replace = 1'b1;
        do_inv(1'b1, 1'b0, 64'h7000, 16'd0);
        replace = 1'b0;
        lookup(64'h7000, 16'd1);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL invrep_same_va: got %b want 1", hit); end
    endtask

    task automatic test_reset_mid();
        va = 64'h7000; asid = 16'd1; req = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; req = 1'b0;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL midreset_hit: got %b want 0", hit); end
        lookup(64'h7000, 16'd1);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL midreset_lost: got %b want 0", hit); end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; active = 1'b1; req = 1'b0; va = '0; asid = '0;
        replace = 1'b0; inv = 1'b0; inv_use_va = 1'b0; inv_use_asid = 1'b0;
        inv_va = '0; inv_asid = '0;
        set_refill(64'h0, 64'h0, 16'd0, 1'b0, 2'd0, 5'b00000);
        #1;
        test_reset();
        test_4k();
        test_superpage();
        test_fill();
        test_inv();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlb_asid_sp.md
Name: tlb_asid_sp

Overview:
- Parametrised successor to the small fully-associative L1 TLB.
- Adds ASID tagging, global pages, Sv39 superpages (4K/2M/1G), execute/user permissions, sfence.vma-style selective invalidation, and an allocator that prefers invalid entries.
- Sits between the load/store or fetch address path and the page-table walker. Lookup has one-cycle registered latency; refills come from the walker via the replace port.

Parameters:
- LG_N, 3, log2 of entry count (N = 1<<LG_N, fully associative).
- ASID_W, 16, ASID tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clear  in  1  invalidate all entries
- active  in  1  translation enabled; 0 = bare pass-through
- req  in  1  lookup request
- va  in  64  lookup virtual address
- asid  in  ASID_W  current ASID
- pa  out  64  translated physical address
- hit  out  1  translation valid
- dirty, readable, writable, executable, user  out  1 each  permission bits of the hit entry
- replace  in  1  refill strobe
- replace_va  in  64  refill virtual address
- replace_pa  in  64  refill physical address, page-aligned
- replace_asid  in  ASID_W  refill ASID
- replace_global  in  1  refill global bit
- replace_size  in  2  page size: 0=4K, 1=2M, 2=1G; 3 is illegal and is treated as 4K
- replace_dirty, replace_readable, replace_writable, replace_executable, replace_user  in  1 each  refill permissions
- inv  in  1  selective invalidate strobe
- inv_use_va, inv_use_asid  in  1 each  invalidate qualifiers
- inv_va  in  64  invalidate address
- inv_asid  in  ASID_W  invalidate ASID

Behaviour:
- Each entry holds: valid, VPN va[38:12] (27b), PPN pa[55:12] (44b), ASID, global, size, and the five permission bits.
- VPN match by size:
  - 4K compares vpn[26:0].
  - 2M compares vpn[26:9].
  - 1G compares vpn[26:18].
- Entry hit = valid & VPN match & (global | entry.asid == asid).
- If several entries hit, the lowest index wins.
- Lookup outputs are registered: a request in cycle T is visible in cycle T+1.
- When active=1:
  - hit <= req & any-hit.
  - pa <= {8'b0, PPN, va[11:0]} for 4K.
  - pa <= {8'b0, PPN[43:9], va[20:0]} for 2M.
  - pa <= {8'b0, PPN[43:18], va[29:0]} for 1G.
  - Permission outputs come from the winning entry. On a miss, all permission outputs are 0.
- When active=0: hit <= 1, pa <= va, and all five permission outputs <= 1.
- Reset values: hit=0, pa=0, all permission outputs 0, all valid bits 0, round-robin pointer r_cnt=0.
- Replace target selection, first rule that applies:
  - (a) An entry matching replace_va/replace_asid under the same size and match rule, so no duplicates are created.
  - (b) The lowest-index invalid entry.
  - (c) The entry at r_cnt.
- Refill write: the target entry is written and marked valid at the clock edge.
- r_cnt increments (mod N) only when rule (c) is used.
- Invalidate semantics for an inv pulse, following sfence.vma:
  - use_va=0, use_asid=0: all entries are invalidated.
  - use_va=1, use_asid=0: entries whose VPN matches inv_va are invalidated, for any ASID and including global entries.
  - use_va=0, use_asid=1: non-global entries with asid == inv_asid are invalidated.
  - use_va=1, use_asid=1: non-global entries matching both inv_va and inv_asid are invalidated.
- Priority within one cycle: reset > clear > inv > replace.
  - reset or clear: all valid bits are cleared and any replace that cycle is dropped.
  - inv and replace together: the invalidate is applied first, then the refill is written. The refilled entry ends valid even if it matches the invalidate.
  - Replace target selection uses the pre-invalidate valid bits.
- A lookup in the same cycle as replace, inv or clear sees the pre-update state. The new state is visible to a lookup issued in the following cycle.
- Reset asserted mid-stream: the next cycle's hit=0 regardless of req. All entries are lost.
- Address bits va[63:39] are not checked. Canonical-address faults are the caller's responsibility.

Test Plan:
- Reset, then active=1 and req on va 0x1234 -> next cycle hit=0, pa=0, permission outputs 0. With active=0 and va=0xDEAD_B000 -> hit=1, pa=0xDEAD_B000, permission outputs all 1.
- Refill 4K entry (va 0x4000_5000 -> pa 0x8_0001_2000, asid 3, R/W=1), then look up va 0x4000_5ABC with asid 3 -> hit=1, pa=0x8_0001_2ABC, writable=1. Same lookup with asid 4 -> hit=0. Set global and repeat with asid 4 -> hit=1.
- Refill 2M page (va 0x4020_0000 -> pa 0x8000_0000, size 1) -> va 0x4023_4567 gives pa 0x8003_4567. Refill 1G page (va 0x8000_0000 -> pa 0x1_0000_0000, size 2) -> va 0xBFFF_FFF0 gives pa 0x1_3FFF_FFF0.
- Fill N+2 distinct pages with LG_N=3 -> entries 0-7 fill in order. The 9th refill lands at index 0 and the 10th at index 1. Re-refilling an existing VPN/ASID overwrites in place without moving r_cnt.
- Selective invalidate:
  - Entries: A (asid 1), B (asid 2), G (global, asid 1).
  - inv use_asid=1, inv_asid=1 -> A invalid, B and G still hit.
  - inv use_va=1 on G's va -> G invalid.
  - inv with both qualifiers 0 -> all invalid.
- Same-cycle events:
  - inv-all together with replace of X -> only X valid afterwards.
  - clear together with replace -> nothing valid.
  - A lookup issued in the same cycle as the replace misses. The same lookup one cycle later hits.
